// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB bypass, load-use stall and flush
module id_ex_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [31:0]       rd1,
    input  logic [31:0]       rd2,
    input  logic              wb_we,
    input  logic [4:0]        wb_wa,
    input  logic [31:0]       wb_wd,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [31:0]       ex_op1,
    output logic [31:0]       ex_op2,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [31:0] op1;
    logic [31:0] op2;
    logic        haz;
    logic        bubble;

    // Resolve operands: x0 reads zero, a same-cycle WB write overrides the stale regfile value
    always_comb begin
        op1 = rd1;
        op2 = rd2;
        if (id_rs1 == 5'd0)
            op1 = 32'd0;
        else if (wb_we && (wb_wa == id_rs1))
            op1 = wb_wd;
        if (id_rs2 == 5'd0)
            op2 = 32'd0;
        else if (wb_we && (wb_wa == id_rs2))
            op2 = wb_wd;
    end

    // Load in EX whose result the ID instruction needs; a flush makes the ID instruction irrelevant
    assign haz = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    assign stall  = haz && !flush;
    assign bubble = flush || haz || !id_valid;

    // EX register: bubble on flush, hazard or empty ID, otherwise capture the decoded instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= 32'd0;
            ex_imm       <= 32'd0;
            ex_rs1       <= 5'd0;
            ex_rs2       <= 5'd0;
            ex_rd        <= 5'd0;
            ex_op1       <= 32'd0;
            ex_op2       <= 32'd0;
            ex_ctrl      <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (bubble) begin
            ex_valid     <= 1'b0;
            ex_pc        <= 32'd0;
            ex_imm       <= 32'd0;
            ex_rs1       <= 5'd0;
            ex_rs2       <= 5'd0;
            ex_rd        <= 5'd0;
            ex_op1       <= 32'd0;
            ex_op2       <= 32'd0;
            ex_ctrl      <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else begin
            ex_valid     <= 1'b1;
            ex_pc        <= id_pc;
            ex_imm       <= id_imm;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
            ex_op1       <= op1;
            ex_op2       <= op2;
            ex_ctrl      <= id_ctrl;
            ex_reg_write <= id_reg_write;
            ex_mem_read  <= id_mem_read;
            ex_mem_write <= id_mem_write;
        end
    end

    // Saturating event counters, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && id_valid && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed plus randomized check of id_ex_stage against a reference model
module tb_id_ex_stage;

    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;
    localparam int CMAX   = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic              id_use_rs1, id_use_rs2;
    logic [31:0]       id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_reg_write, id_mem_read, id_mem_write;
    logic [31:0]       rd1, rd2;
    logic              wb_we;
    logic [4:0]        wb_wa;
    logic [31:0]       wb_wd;
    logic              flush;
    logic              stall;
    logic              ex_valid;
    logic [31:0]       ex_pc, ex_imm;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic [31:0]       ex_op1, ex_op2;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_reg_write, ex_mem_read, ex_mem_write;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .rd1(rd1), .rd2(rd2),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_ctrl(ex_ctrl),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // reference model of what EX should hold
    typedef struct {
        logic              valid;
        logic [31:0]       pc, imm, op1, op2;
        logic [4:0]        rs1, rs2, rd;
        logic [CTRL_W-1:0] ctrl;
        logic              rw, mr, mw;
    } ex_t;
    ex_t m;
    int  m_sc, m_fc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ex_t empty_ex();
        ex_t e;
        e.valid = 0; e.pc = 0; e.imm = 0; e.op1 = 0; e.op2 = 0;
        e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.ctrl = 0; e.rw = 0; e.mr = 0; e.mw = 0;
        return e;
    endfunction

    function automatic logic [31:0] source_value(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return 32'd0;
        if (wb_we && wb_wa == idx) return wb_wd;
        return rf;
    endfunction

    function automatic logic model_haz();
        if (!(m.valid && m.mr && m.rd != 0 && id_valid)) return 1'b0;
        return (id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd);
    endfunction

    task automatic model_reset();
        m = empty_ex();
        m_sc = 0;
        m_fc = 0;
    endtask

    task automatic check_ex(input string p);
        chk({p, "_valid"}, ex_valid, m.valid);
        chk({p, "_pc"}, ex_pc, m.pc);
        chk({p, "_imm"}, ex_imm, m.imm);
        chk({p, "_rs1"}, ex_rs1, m.rs1);
        chk({p, "_rs2"}, ex_rs2, m.rs2);
        chk({p, "_rd"}, ex_rd, m.rd);
        chk({p, "_op1"}, ex_op1, m.op1);
        chk({p, "_op2"}, ex_op2, m.op2);
        chk({p, "_ctrl"}, ex_ctrl, m.ctrl);
        chk({p, "_rw"}, ex_reg_write, m.rw);
        chk({p, "_mr"}, ex_mem_read, m.mr);
        chk({p, "_mw"}, ex_mem_write, m.mw);
        chk({p, "_scnt"}, stall_cnt, m_sc);
        chk({p, "_fcnt"}, flush_cnt, m_fc);
    endtask

    // called just after a negedge with inputs already driven; returns just after the next negedge
    task automatic step(input string p);
        logic e_stall, kill;
        ex_t  nxt;
        #1;
        e_stall = model_haz() && !flush;
        chk({p, "_stall"}, stall, e_stall);
        kill = flush || model_haz() || !id_valid;
        if (kill) nxt = empty_ex();
        else begin
            nxt.valid = 1; nxt.pc = id_pc; nxt.imm = id_imm;
            nxt.rs1 = id_rs1; nxt.rs2 = id_rs2; nxt.rd = id_rd;
            nxt.op1 = source_value(id_rs1, rd1);
            nxt.op2 = source_value(id_rs2, rd2);
            nxt.ctrl = id_ctrl; nxt.rw = id_reg_write; nxt.mr = id_mem_read; nxt.mw = id_mem_write;
        end
        @(posedge clk);
        #1;
        m = nxt;
        if (e_stall && m_sc < CMAX) m_sc++;
        if (flush && id_valid && m_fc < CMAX) m_fc++;
        check_ex(p);
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_imm = 0; id_ctrl = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        rd1 = 0; rd2 = 0; wb_we = 0; wb_wa = 0; wb_wd = 0; flush = 0;
    endtask

    task automatic rand_inputs();
        id_valid = ($urandom_range(0, 7) != 0);
        id_pc = $urandom; id_imm = $urandom; id_ctrl = CTRL_W'($urandom);
        id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3));
        id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
        id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
        id_mem_write = 1'($urandom);
        rd1 = $urandom; rd2 = $urandom;
        wb_we = 1'($urandom); wb_wa = 5'($urandom_range(0, 3)); wb_wd = $urandom;
        flush = ($urandom_range(0, 7) == 0);
    endtask

    task automatic present_load(input logic [4:0] rd);
        idle();
        id_valid = 1; id_rd = rd; id_mem_read = 1; id_reg_write = 1; id_pc = 32'h100;
    endtask

    task automatic present_user(input logic use2);
        idle();
        id_valid = 1; id_rs2 = 7; id_use_rs2 = use2; id_rd = 3; id_pc = 32'h104; rd2 = 32'h22;
    endtask

    initial begin
        // reset with busy inputs
        rst_n = 0;
        model_reset();
        rand_inputs();
        id_valid = 1;
        #2;
        chk("rst_stall", stall, 0);
        check_ex("rst0");
        @(negedge clk);
        rand_inputs();
        id_valid = 1;
        #1;
        check_ex("rst1");
        chk("rst1_stall", stall, 0);
        @(negedge clk);
        rst_n = 1;
        idle();

        // pass-through
        id_valid = 1; id_pc = 32'h40; id_imm = 32'hFFFF_FFF0; id_ctrl = 8'hA5;
        id_rs1 = 5; rd1 = 99; id_rs2 = 10; rd2 = 12345; id_rd = 2; id_reg_write = 1;
        step("pt");
        chk("pt_op1_const", ex_op1, 99);
        chk("pt_op2_const", ex_op2, 12345);

        // WB bypass then x0
        idle();
        id_valid = 1; wb_we = 1; wb_wa = 5; wb_wd = 77; rd1 = 99; id_rs1 = 5;
        step("byp");
        chk("byp_op1_const", ex_op1, 77);
        idle();
        id_valid = 1; wb_we = 1; wb_wa = 0; wb_wd = 55; id_rs1 = 0; rd1 = 33;
        step("x0");
        chk("x0_op1_const", ex_op1, 0);

        // load-use: stall one cycle, bubble, then capture
        present_load(7);  step("lu_ld");
        present_user(1);  step("lu_stall");
        chk("lu_bubble", ex_valid, 0);
        chk("lu_scnt_const", stall_cnt, 1);
        step("lu_cap");
        chk("lu_cap_valid", ex_valid, 1);
        chk("lu_cap_stall_after", stall, 0);

        // no stall when rs2 not used
        present_load(7);  step("nu_ld");
        present_user(0);  step("nu_pass");
        chk("nu_valid", ex_valid, 1);

        // flush beats hazard
        present_load(7);  step("fl_ld");
        present_user(1);  flush = 1;
        step("fl");
        chk("fl_bubble", ex_valid, 0);
        chk("fl_fcnt_const", flush_cnt, 1);
        chk("fl_scnt_const", stall_cnt, 1);

        // reset mid-stall clears EX immediately; first post-reset cycle cannot stall
        present_load(7);  step("rs_ld");
        present_user(1);
        #1;
        chk("rs_pre_stall", stall, 1);
        rst_n = 0;
        #1;
        model_reset();
        chk("rs_stall", stall, 0);
        check_ex("rs_async");
        @(negedge clk);
        rst_n = 1;
        step("rs_first");

        // saturation of stall counter
        for (int i = 0; i < 20; i++) begin
            present_load(7);  step("sat_ld");
            present_user(1);  step("sat_st");
            step("sat_cap");
        end
        chk("sat_scnt_const", stall_cnt, CMAX);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
